// File: rtl/g711_coder_stream.sv
// Multi-channel G.711 A-law / mu-law encoder, three-stage valid/ready pipe.
// One global stall enable keeps every stage in lockstep with the sink.
module g711_coder_stream #(
   parameter  int CHANNELS  = 4,
   parameter  int ALAW_G711 = 0,
   localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [15:0]         in_pcm,
   input  logic [CHAN_W-1:0]   in_chan,
   input  logic [CHANNELS-1:0] law_mask,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_code,
   output logic [CHAN_W-1:0]   out_chan,
   output logic                out_clip,
   output logic                err_chan
);

   localparam int MW = 1 << CHAN_W;
   localparam logic [CHAN_W:0] CH_LIM = (CHAN_W+1)'(CHANNELS);

   logic              en, acc, bad;
   logic [MW-1:0]     mask_ext;

   logic              s1_vld_q, s1_law_q;
   logic [13:0]       s1_pcm_q;
   logic [CHAN_W-1:0] s1_chan_q;
   logic              err_q;

   logic              s2_vld_q, s2_law_q, s2_neg_q, s2_clip_q;
   logic [11:0]       s2_mag_q;
   logic [CHAN_W-1:0] s2_chan_q;

   logic              out_vld_q, out_clip_q;
   logic [7:0]        out_code_q;
   logic [CHAN_W-1:0] out_chan_q;

   assign en       = !out_vld_q | out_ready;
   assign in_ready = en;
   assign acc      = in_valid & en;
   assign bad      = {1'b0, in_chan} >= CH_LIM;
   assign mask_ext = MW'(law_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_law_q  <= 1'b0;
         s1_pcm_q  <= '0;
         s1_chan_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= acc & bad;
         if (en) begin
            s1_vld_q  <= acc & !bad;
            s1_law_q  <= mask_ext[in_chan];
            s1_pcm_q  <= in_pcm[15:2];
            s1_chan_q <= in_chan;
         end
      end
   end

   // S2 keeps magnitude (A-law) or biased magnitude (mu-law), bit 0 dropped
   logic [12:0] ax, a_abs;
   logic [13:0] m_abs;
   logic [12:0] m_sat;
   logic        a_clip, m_clip;
   logic [12:0] s2_full_d;
   logic [11:0] s2_mag_d;
   logic        s2_clip_d;

   always_comb begin
      ax        = s1_pcm_q[13:1];
      a_abs     = ax[12] ? (~ax + 13'd1) : ax;
      m_abs     = s1_pcm_q[13] ? (~s1_pcm_q + 14'd1) : s1_pcm_q;
      a_clip    = a_abs[12];
      m_clip    = m_abs > 14'd8158;
      m_sat     = m_clip ? 13'd8158 : m_abs[12:0];
      s2_full_d = a_clip ? 13'd4095 : a_abs;
      s2_clip_d = a_clip;
      if (s1_law_q) begin
         s2_full_d = m_sat + 13'd33;
         s2_clip_d = m_clip;
      end
      s2_mag_d  = s2_full_d[12:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q  <= 1'b0;
         s2_law_q  <= 1'b0;
         s2_neg_q  <= 1'b0;
         s2_clip_q <= 1'b0;
         s2_mag_q  <= '0;
         s2_chan_q <= '0;
      end else if (en) begin
         s2_vld_q  <= s1_vld_q;
         s2_law_q  <= s1_law_q;
         s2_neg_q  <= s1_pcm_q[13];
         s2_clip_q <= s2_clip_d;
         s2_mag_q  <= s2_mag_d;
         s2_chan_q <= s1_chan_q;
      end
   end

   logic [2:0] seg;
   logic [3:0] shamt;
   logic [3:0] mant;
   logic [7:0] code_d;

   always_comb begin
      seg    = '0;
      shamt  = '0;
      if (s2_law_q) begin
         for (int i = 0; i < 8; i++)
            if (s2_mag_q[4+i]) seg = 3'(i);
         shamt = {1'b0, seg};
      end else begin
         for (int i = 0; i < 7; i++)
            if (s2_mag_q[4+i]) seg = 3'(i + 1);
         if (seg != 3'd0) shamt = {1'b0, seg} - 4'd1;
      end
      mant   = 4'(s2_mag_q >> shamt);
      code_d = {s2_neg_q, seg, mant};
      if (s2_law_q)
         code_d = ~{s2_neg_q, seg, mant};
      else if (ALAW_G711 != 0)
         code_d = {~s2_neg_q, seg, mant} ^ 8'h55;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_clip_q <= 1'b0;
         out_code_q <= '0;
         out_chan_q <= '0;
      end else if (en) begin
         out_vld_q  <= s2_vld_q;
         out_clip_q <= s2_vld_q & s2_clip_q;
         if (s2_vld_q) begin
            out_code_q <= code_d;
            out_chan_q <= s2_chan_q;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_code  = out_code_q;
   assign out_chan  = out_chan_q;
   assign out_clip  = out_clip_q;
   assign err_chan  = err_q;

endmodule

// File: tb/tb_g711_coder_stream.sv
// Bench for g711_coder_stream: directed vectors, stalls, bad tags,
// mid-flight reset and a random stream against an arithmetic model.
module tb_g711_coder_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready;
   logic [15:0] in_pcm;
   logic [1:0]  in_chan;
   logic [3:0]  law_mask;

   logic        rdy0, ov0, clip0, err0;
   logic [7:0]  code0;
   logic [1:0]  chan0;
   logic        rdy1, ov1, clip1, err1;
   logic [7:0]  code1;
   logic [1:0]  chan1;

   int checks = 0;
   int failures = 0;
   int sent;
   logic [10:0] sbq[$];
   logic [10:0] olog[$];
   logic [10:0] hold_v;
   logic exp_err = 1'b0;
   logic hv = 1'b0;
   logic acc = 1'b0;

   g711_coder_stream #(.CHANNELS(3), .ALAW_G711(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .in_pcm(in_pcm), .in_chan(in_chan), .law_mask(law_mask[2:0]),
      .out_valid(ov0), .out_ready(out_ready), .out_code(code0),
      .out_chan(chan0), .out_clip(clip0), .err_chan(err0));

   g711_coder_stream #(.CHANNELS(4), .ALAW_G711(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .in_pcm(in_pcm), .in_chan(in_chan), .law_mask(law_mask),
      .out_valid(ov1), .out_ready(out_ready), .out_code(code1),
      .out_chan(chan1), .out_clip(clip1), .err_chan(err1));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Segment from thresholds, mantissa by division: {clip, code}
   function automatic logic [8:0] model(input int pcm, input bit mu);
      int x, mag, b, seg, mant, code;
      bit neg, clip;
      clip = 1'b0;
      seg = 0;
      if (!mu) begin
         x = pcm >>> 3;
         neg = x < 0;
         mag = neg ? -x : x;
         if (mag > 4095) begin mag = 4095; clip = 1'b1; end
         for (int s = 1; s <= 7; s++) if (mag >= (16 << s)) seg = s;
         mant = (seg < 2) ? (mag / 2) % 16 : (mag / (1 << seg)) % 16;
         code = (neg ? 128 : 0) + seg * 16 + mant;
      end else begin
         x = pcm >>> 2;
         neg = x < 0;
         mag = neg ? -x : x;
         if (mag > 8158) begin mag = 8158; clip = 1'b1; end
         b = mag + 33;
         for (int s = 1; s <= 7; s++) if (b >= (32 << s)) seg = s;
         mant = (b / (2 << seg)) % 16;
         code = 255 - ((neg ? 128 : 0) + seg * 16 + mant);
      end
      return {clip, 8'(code)};
   endfunction

   task automatic cyc();
      logic [10:0] e;
      logic nerr;
      #1;
      nerr = 1'b0;
      acc = 1'b0;
      chk("in_ready", rdy0, !ov0 || out_ready);
      if (hv) begin
         chk("hold_valid", ov0, 1);
         chk("hold_data", {chan0, clip0, code0}, hold_v);
      end
      hv = ov0 && !out_ready;
      hold_v = {chan0, clip0, code0};
      if (ov0 && out_ready) begin
         olog.push_back({chan0, clip0, code0});
         if (sbq.size() == 0) chk("no_spurious_out", ov0, 0);
         else begin
            e = sbq.pop_front();
            chk("out_word", {chan0, clip0, code0}, e);
         end
      end
      chk("err_chan", err0, exp_err);
      if (in_valid && rdy0) begin
         acc = 1'b1;
         if (in_chan >= 2'd3) nerr = 1'b1;
         else sbq.push_back({in_chan,
                model(int'($signed(in_pcm)), law_mask[in_chan])});
      end
      exp_err = nerr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv(input logic v, input logic [15:0] p,
                      input logic [1:0] c, input logic r);
      in_valid = v;
      in_pcm = p;
      in_chan = c;
      out_ready = r;
      cyc();
   endtask

   function automatic logic [15:0] rpcm();
      logic [15:0] ext[4];
      ext[0] = 16'h8000; ext[1] = 16'h7FFF;
      ext[2] = 16'hFFFF; ext[3] = 16'h0000;
      if ($urandom_range(0, 7) == 0) return ext[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_pcm = '0;
      in_chan = '0;
      law_mask = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", ov0, 0);
      chk("rst_code", code0, 8'h00);
      chk("rst_chan", chan0, 0);
      chk("rst_clip", clip0, 0);
      chk("rst_err", err0, 0);
      chk("rst_ready", rdy0, 1);
      rst_n = 1'b1;

      // latency and basic A-law vectors
      drv(1, 16'd1000, 0, 1);
      drv(0, 0, 0, 1);
      chk("lat_early", ov0, 0);
      drv(0, 0, 0, 1);
      chk("lat_valid", ov0, 1);
      chk("alaw_1000", code0, 8'h2F);
      chk("alaw_chan", chan0, 0);
      chk("alaw_clip", clip0, 0);
      chk("g711_valid", ov1, 1);
      chk("g711_1000", code1, 8'hFA);
      chk("g711_clip", {err1, clip1, chan1}, 0);
      drv(0, 0, 0, 1);

      // mu-law vectors and saturation
      law_mask = 4'b0010;
      olog.delete();
      drv(1, 16'd1000, 1, 1);
      drv(1, 16'd0, 1, 1);
      drv(1, 16'h8000, 1, 1);
      drv(1, 16'h8000, 0, 1);
      repeat (4) drv(0, 0, 0, 1);
      chk("vec_count", olog.size(), 4);
      if (olog.size() == 4) begin
         chk("mu_1000", olog[0], {2'd1, 1'b0, 8'hCE});
         chk("mu_0", olog[1], {2'd1, 1'b0, 8'hFF});
         chk("mu_min", olog[2], {2'd1, 1'b1, 8'h00});
         chk("a_min", olog[3], {2'd0, 1'b1, 8'hFF});
      end

      // out-of-range channel tag between good neighbours
      law_mask = 4'b0100;
      olog.delete();
      drv(1, 16'd123, 0, 1);
      drv(1, 16'd500, 3, 1);
      chk("err_pulse", err0, 1);
      drv(1, -16'sd777, 2, 1);
      chk("err_clear", err0, 0);
      repeat (4) drv(0, 0, 0, 1);
      chk("bad_count", olog.size(), 2);
      if (olog.size() == 2) begin
         chk("bad_nb0", olog[0][10:9], 0);
         chk("bad_nb2", olog[1][10:9], 2);
      end

      // 8-sample burst with a 5-cycle sink stall
      olog.delete();
      sent = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = sent < 8;
         in_pcm = rpcm();
         in_chan = 2'($urandom_range(0, 2));
         law_mask = 4'($urandom);
         out_ready = !(i >= 4 && i < 9);
         cyc();
         if (acc) sent++;
      end
      repeat (6) drv(0, 0, 0, 1);
      chk("stall_sent", sent, 8);
      chk("stall_count", olog.size(), 8);
      chk("stall_sb_empty", sbq.size(), 0);

      // random traffic, mask churn, backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid = $urandom_range(0, 3) != 0;
         in_pcm = rpcm();
         in_chan = 2'($urandom_range(0, 3));
         law_mask = 4'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         cyc();
      end
      repeat (8) drv(0, 0, 0, 1);
      chk("rand_sb_empty", sbq.size(), 0);

      // reset with three samples in flight
      law_mask = 4'b0000;
      drv(1, 16'd100, 0, 1);
      drv(1, 16'd200, 1, 1);
      drv(1, 16'd300, 2, 1);
      chk("pre_rst_valid", ov0, 1);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_valid", ov0, 0);
      chk("mid_rst_code", code0, 8'h00);
      chk("mid_rst_chan", chan0, 0);
      chk("mid_rst_clip", clip0, 0);
      sbq.delete();
      exp_err = 1'b0;
      hv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      olog.delete();
      repeat (6) drv(0, 0, 0, 1);
      chk("post_rst_none", olog.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
